// File: rtl/rf_writeback_pkg.sv
// rf_writeback_pkg: shared widths, constants and FIFO count encoding for the write-back block
package rf_writeback_pkg;
    localparam int DATA_W = 16;
    localparam int REG_AW = 3;
    localparam int REG_N  = 2 ** REG_AW;
    localparam logic [15:0] ZERO16 = 16'h0000;

    typedef enum logic [1:0] {
        CNT_EMPTY = 2'd0,
        CNT_ONE   = 2'd1,
        CNT_FULL  = 2'd2
    } fifo_cnt_e;
endpackage

// File: rtl/rf_writeback_fifo2.sv
// wb_fifo2: two-entry in-order load buffer holding {reg, data} with push/pop and registered count
module wb_fifo2
    import rf_writeback_pkg::*;
#(
    parameter int DW = DATA_W,
    parameter int AW = REG_AW
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          push,
    input  logic          pop,
    input  logic [AW-1:0] in_reg,
    input  logic [DW-1:0] in_data,
    output logic [AW-1:0] head_reg,
    output logic [DW-1:0] head_data,
    output fifo_cnt_e     count
);
    logic [AW-1:0] reg_q [2];
    logic [DW-1:0] data_q [2];
    logic          wr_ptr, rd_ptr;
    fifo_cnt_e     count_d;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count  <= CNT_EMPTY;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
        end else begin
            count <= count_d;
            if (push) begin
                reg_q[wr_ptr]  <= in_reg;
                data_q[wr_ptr] <= in_data;
                wr_ptr         <= ~wr_ptr;
            end
            if (pop)
                rd_ptr <= ~rd_ptr;
        end
    end

    always_comb begin
        count_d = count;
        unique case (count)
            CNT_EMPTY: count_d = (push && !pop) ? CNT_ONE : CNT_EMPTY;
            CNT_ONE:   count_d = (push && !pop) ? CNT_FULL : (pop && !push) ? CNT_EMPTY : CNT_ONE;
            CNT_FULL:  count_d = (pop && !push) ? CNT_ONE : CNT_FULL;
            default:   count_d = CNT_EMPTY;
        endcase
    end

    assign head_reg  = reg_q[rd_ptr];
    assign head_data = data_q[rd_ptr];
endmodule

// File: rtl/rf_writeback.sv
// rf_writeback: merges ALU and buffered load results into one registered register-file write, tracks busy registers
module rf_writeback
    import rf_writeback_pkg::*;
#(
    parameter int DATA_W = rf_writeback_pkg::DATA_W,
    parameter int REG_AW = rf_writeback_pkg::REG_AW,
    parameter int REG_N  = 2 ** REG_AW
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              alu_valid_i,
    input  logic [REG_AW-1:0] alu_reg_i,
    input  logic [DATA_W-1:0] alu_data_i,
    input  logic              mem_valid_i,
    output logic              mem_ready_o,
    input  logic [REG_AW-1:0] mem_reg_i,
    input  logic [DATA_W-1:0] mem_data_i,
    input  logic              issue_i,
    input  logic [REG_AW-1:0] issue_reg_i,
    output logic [REG_N-1:0]  busy_o,
    output logic              regWrite_o,
    output logic [REG_AW-1:0] reg3_o,
    output logic [DATA_W-1:0] data3_o
);
    localparam logic [REG_N-1:0] ONE_HOT0 = {{(REG_N-1){1'b0}}, 1'b1};

    fifo_cnt_e         count;
    logic [REG_AW-1:0] head_reg, sel_reg;
    logic [DATA_W-1:0] head_data, sel_data;
    logic              mem_acc, fifo_nempty, push, pop, sel_valid;
    logic [REG_N-1:0]  clr_mask, set_mask, busy_d;

    // Ready depends only on the registered count so producers see no combinational path
    assign mem_ready_o = (count != CNT_FULL);
    assign mem_acc     = mem_valid_i & mem_ready_o;
    assign fifo_nempty = (count != CNT_EMPTY);

    always_comb begin
        pop       = !alu_valid_i && fifo_nempty;
        push      = mem_acc && (alu_valid_i || fifo_nempty);
        sel_valid = alu_valid_i || fifo_nempty || mem_acc;
        sel_reg   = alu_valid_i ? alu_reg_i  : fifo_nempty ? head_reg  : mem_reg_i;
        sel_data  = alu_valid_i ? alu_data_i : fifo_nempty ? head_data : mem_data_i;
        clr_mask  = sel_valid ? (ONE_HOT0 << sel_reg) : '0;
        set_mask  = issue_i ? (ONE_HOT0 << issue_reg_i) : '0;
        busy_d    = (busy_o & ~clr_mask) | set_mask;
    end

    wb_fifo2 #(.DW(DATA_W), .AW(REG_AW)) u_fifo (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .push      (push),
        .pop       (pop),
        .in_reg    (mem_reg_i),
        .in_data   (mem_data_i),
        .head_reg  (head_reg),
        .head_data (head_data),
        .count     (count)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            busy_o     <= '0;
            regWrite_o <= 1'b0;
            reg3_o     <= '0;
            data3_o    <= '0;
        end else begin
            busy_o     <= busy_d;
            regWrite_o <= sel_valid;
            if (sel_valid) begin
                reg3_o  <= sel_reg;
                data3_o <= sel_data;
            end
        end
    end
endmodule

// File: tb/tb_rf_writeback.sv
// tb_rf_writeback: randomized and directed checks of rf_writeback against a queue-based reference model
module tb_rf_writeback;
    import rf_writeback_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_i, alu_valid_i, mem_valid_i, mem_ready_o, issue_i, regWrite_o;
    logic [2:0]  alu_reg_i, mem_reg_i, issue_reg_i, reg3_o;
    logic [15:0] alu_data_i, mem_data_i, data3_o;
    logic [7:0]  busy_o;

    always #5 clk_i = ~clk_i;

    rf_writeback dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .alu_valid_i(alu_valid_i), .alu_reg_i(alu_reg_i), .alu_data_i(alu_data_i),
        .mem_valid_i(mem_valid_i), .mem_ready_o(mem_ready_o), .mem_reg_i(mem_reg_i), .mem_data_i(mem_data_i),
        .issue_i(issue_i), .issue_reg_i(issue_reg_i), .busy_o(busy_o),
        .regWrite_o(regWrite_o), .reg3_o(reg3_o), .data3_o(data3_o)
    );

    typedef struct { logic [2:0] r; logic [15:0] d; } ld_t;
    ld_t         q[$];
    logic        exp_we, last_acc;
    logic [2:0]  exp_reg;
    logic [15:0] exp_data;
    logic [7:0]  exp_busy;
    int          n_cmp = 0, n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle();
        rst_i = 0; alu_valid_i = 0; alu_reg_i = 0; alu_data_i = 0;
        mem_valid_i = 0; mem_reg_i = 0; mem_data_i = 0; issue_i = 0; issue_reg_i = 0;
    endtask

    // Model: loads wait in a queue behind the ALU; one write per cycle, ALU first, then oldest load
    task automatic step();
        ld_t w;
        logic wv, acc;
        chk("mem_ready", mem_ready_o, q.size() != 2);
        acc = !rst_i && mem_valid_i && q.size() < 2;
        if (rst_i) begin
            q.delete(); exp_we = 0; exp_reg = 0; exp_data = 0; exp_busy = 0;
        end else begin
            wv = 1;
            if (alu_valid_i) begin
                w.r = alu_reg_i; w.d = alu_data_i;
                if (acc) q.push_back('{mem_reg_i, mem_data_i});
            end else if (q.size() > 0) begin
                w = q.pop_front();
                if (acc) q.push_back('{mem_reg_i, mem_data_i});
            end else if (acc) begin
                w.r = mem_reg_i; w.d = mem_data_i;
            end else
                wv = 0;
            exp_we = wv;
            if (wv) begin
                exp_reg = w.r; exp_data = w.d; exp_busy[w.r] = 1'b0;
            end
            if (issue_i) exp_busy[issue_reg_i] = 1'b1;
        end
        last_acc = acc;
        @(posedge clk_i); #1;
        chk("regWrite", regWrite_o, exp_we);
        chk("reg3", reg3_o, exp_reg);
        chk("data3", data3_o, exp_data);
        chk("busy", busy_o, exp_busy);
    endtask

    task automatic rand_in(input int alu_pct);
        rst_i = ($urandom_range(0, 199) == 0);
        alu_valid_i = ($urandom_range(0, 99) < alu_pct);
        alu_reg_i = 3'($urandom); alu_data_i = 16'($urandom);
        issue_i = $urandom_range(0, 1); issue_reg_i = 3'($urandom);
        if (!(mem_valid_i && !last_acc)) begin
            mem_valid_i = $urandom_range(0, 1);
            mem_reg_i = 3'($urandom); mem_data_i = 16'($urandom);
        end
    endtask

    logic [2:0]  ld_r [3] = '{3'd4, 3'd5, 3'd6};
    logic [15:0] ld_d [3] = '{16'd1, 16'd2, 16'd3};
    int li;

    initial begin
        idle(); rst_i = 1; alu_valid_i = 1;
        @(posedge clk_i); #1;
        q.delete(); exp_we = 0; exp_reg = 0; exp_data = 0; exp_busy = 0; last_acc = 0;
        step(); step();
        idle(); chk("rst_ready", mem_ready_o, 1);
        chk("rst_we", regWrite_o, 0);
        step();
        // single ALU write
        alu_valid_i = 1; alu_reg_i = 3; alu_data_i = 16'h1234; step();
        chk("alu_data", data3_o, 16'h1234);
        idle(); step();
        chk("alu_once", regWrite_o, 0);
        // ALU and load contend
        alu_valid_i = 1; alu_reg_i = 1; alu_data_i = 16'hAAAA;
        mem_valid_i = 1; mem_reg_i = 2; mem_data_i = 16'h5555; step();
        chk("cont_r1", reg3_o, 1);
        idle(); step();
        chk("cont_r2", data3_o, 16'h5555);
        // fill the FIFO behind four ALU cycles, third load held
        li = 0;
        for (int c = 0; c < 8; c++) begin
            alu_valid_i = (c < 4); alu_reg_i = 0; alu_data_i = 16'(c);
            mem_valid_i = (li < 3); mem_reg_i = ld_r[li % 3]; mem_data_i = ld_d[li % 3];
            step();
            if (c == 1) chk("fill_ready_low", mem_ready_o, 0);
            if (last_acc) li++;
        end
        idle(); step();
        // scoreboard: issue r7, load to r7 later, then issue r7 coincident with its write
        issue_i = 1; issue_reg_i = 7; step();
        chk("busy7_set", busy_o[7], 1);
        idle(); step(); step();
        mem_valid_i = 1; mem_reg_i = 7; mem_data_i = 16'hBEEF; step();
        chk("busy7_clr", busy_o[7], 0);
        issue_i = 1; issue_reg_i = 7; mem_data_i = 16'hCAFE; step();
        chk("busy7_keep", busy_o[7], 1);
        // reset mid-operation with a full FIFO and busy 8'hF0
        idle();
        for (int c = 0; c < 4; c++) begin
            alu_valid_i = 1; alu_reg_i = 0; mem_valid_i = 1; mem_reg_i = 3'(c); mem_data_i = 16'(c);
            issue_i = 1; issue_reg_i = 3'(4 + c); step();
        end
        chk("mid_busy", busy_o, 8'hF0);
        chk("mid_full", mem_ready_o, 0);
        rst_i = 1; step();
        idle(); step();
        chk("mid_nowrite", regWrite_o, 0);
        // randomized traffic with varying ALU pressure
        last_acc = 0;
        for (int c = 0; c < 3000; c++) begin
            rand_in(c < 1000 ? 30 : c < 2000 ? 85 : 50);
            step();
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
